// File: rtl/lake_config_loader_pkg.sv
// lake_config_pkg: shared sizing, status-bit layout and FSM type for lake_config_loader
package lake_config_pkg;
  localparam int CFG_WIDTH = 550;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  function automatic int num_words(int cw, int ww);
    return (cw + ww - 1) / ww;
  endfunction
  localparam int NUM_WORDS = num_words(CFG_WIDTH, WORD_W);
  localparam int COMMIT_OFFSET = NUM_WORDS;
  localparam int LAST_WORD_BITS = CFG_WIDTH - (NUM_WORDS - 1) * WORD_W;
  localparam int ST_VALID = 0;
  localparam int ST_ERROR = 1;
  localparam int ST_ARMED = 2;
  typedef enum logic {LOAD = 1'b0, ARMED = 1'b1} cfg_state_t;
endpackage

// File: rtl/lake_config_loader_if.sv
// lake_config_loader_if: serial config write/read bus with readback
interface lake_config_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] config_config_addr;
  logic [WORD_WIDTH-1:0] config_config_data;
  logic config_write;
  logic config_read;
  logic [WORD_WIDTH-1:0] config_read_data;
  logic config_read_valid;
  modport master (
    output config_config_addr, config_config_data, config_write, config_read,
    input config_read_data, config_read_valid
  );
  modport slave (
    input config_config_addr, config_config_data, config_write, config_read,
    output config_read_data, config_read_valid
  );
endinterface

// File: rtl/lake_config_loader_word_mux.sv
// lake_config_word_mux: readback word select with last-word and out-of-range zero fill
module lake_config_word_mux #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NW = 18,
  parameter int LB = 6
) (
  input logic [NW*WORD_WIDTH-1:0] shadow_i,
  input logic [ADDR_WIDTH-1:0] offset_i,
  input logic in_range_i,
  input logic [2:0] status_i,
  output logic [WORD_WIDTH-1:0] word_o
);
  localparam int IW = $clog2(NW);
  localparam logic [WORD_WIDTH-1:0] LAST_MASK = {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - LB);
  logic [WORD_WIDTH-1:0] sel;
  assign sel = shadow_i[int'(offset_i[IW-1:0]) * WORD_WIDTH +: WORD_WIDTH];
  assign word_o = !in_range_i ? '0 :
                  offset_i < ADDR_WIDTH'(NW - 1) ? sel :
                  offset_i == ADDR_WIDTH'(NW - 1) ? sel & LAST_MASK :
                  offset_i == ADDR_WIDTH'(NW) ? WORD_WIDTH'(status_i) : '0;
endmodule

// File: rtl/lake_config_loader.sv
// lake_config_loader: config-bus responder building a shadow image, committed atomically to config_out
module lake_config_loader
  import lake_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = CFG_WIDTH,
  parameter int WORD_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic clk,
  input logic rst_n,
  lake_config_loader_if.slave bus,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic config_valid,
  output logic config_error
);
  localparam int NW = num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int IW = $clog2(NW);
  logic [NW*WORD_WIDTH-1:0] shadow_q;
  logic [NW-1:0] mask_q, mask_d;
  cfg_state_t state_q, state_d;
  logic [CONFIG_WIDTH-1:0] active_q;
  logic valid_q, error_q, error_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_word;
  logic rd_valid_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic borrow, word_hit, wr_word, commit_req, commit_ok;
  logic [IW-1:0] idx;
  logic [2:0] status;
  // borrow out of the subtraction flags addresses below BASE_ADDR
  assign {borrow, offset} = {1'b0, bus.config_config_addr} - {1'b0, BASE_ADDR};
  assign idx = offset[IW-1:0];
  assign word_hit = !borrow && offset < ADDR_WIDTH'(NW);
  assign wr_word = bus.config_write && word_hit;
  assign commit_req = bus.config_write && !borrow && offset == ADDR_WIDTH'(NW) && bus.config_config_data[0];
  assign commit_ok = commit_req && state_q == ARMED;
  assign state_d = &mask_d ? ARMED : LOAD;
  assign error_d = commit_ok ? 1'b0 : commit_req ? 1'b1 : error_q;
  always_comb begin
    mask_d = mask_q;
    if (wr_word) mask_d[idx] = 1'b1;
    if (commit_ok) mask_d = '0;
  end
  always_comb begin
    status = '0;
    status[ST_VALID] = valid_q;
    status[ST_ERROR] = error_q;
    status[ST_ARMED] = state_q == ARMED;
  end
  lake_config_word_mux #(
    .WORD_WIDTH(WORD_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NW(NW), .LB(CONFIG_WIDTH - (NW - 1) * WORD_WIDTH)
  ) u_mux (
    .shadow_i(shadow_q), .offset_i(offset), .in_range_i(!borrow), .status_i(status), .word_o(rd_word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      mask_q <= '0;
      state_q <= LOAD;
      active_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_word) shadow_q[int'(idx) * WORD_WIDTH +: WORD_WIDTH] <= bus.config_config_data;
      mask_q <= mask_d;
      state_q <= state_d;
      error_q <= error_d;
      if (commit_ok) begin
        active_q <= shadow_q[CONFIG_WIDTH-1:0];
        valid_q <= 1'b1;
      end
      rd_valid_q <= bus.config_read;
      if (bus.config_read) rd_data_q <= rd_word;
    end
  end
  assign config_out = active_q;
  assign config_valid = valid_q;
  assign config_error = error_q;
  assign bus.config_read_data = rd_data_q;
  assign bus.config_read_valid = rd_valid_q;
endmodule

// File: tb/tb_lake_config_loader.sv
// tb_lake_config_loader: directed plus randomized checks against an array-based image model
module tb_lake_config_loader;
  localparam int CW = 550;
  localparam int NW = 18;
  localparam logic [31:0] BASE = 32'd4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] config_out;
  logic config_valid, config_error;
  lake_config_loader_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();
  lake_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .config_out(config_out), .config_valid(config_valid), .config_error(config_error)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_sh [NW];
  logic [NW-1:0] m_mask;
  logic [CW-1:0] m_act;
  logic m_val, m_err, m_rv;
  logic [31:0] m_rd;
  task automatic chk(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    foreach (m_sh[i]) m_sh[i] = '0;
    m_mask = '0; m_act = '0; m_val = 0; m_err = 0; m_rv = 0; m_rd = '0;
  endtask
  function automatic logic [CW-1:0] image();
    logic [NW*32-1:0] f;
    for (int i = 0; i < NW; i++) f[i*32 +: 32] = m_sh[i];
    return f[CW-1:0];
  endfunction
  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE) return '0;
    if (off < NW) return (off == NW - 1) ? (m_sh[off] & 32'h3F) : m_sh[off];
    if (off == NW) return {29'b0, &m_mask, m_err, m_val};
    return '0;
  endfunction
  task automatic check_all();
    chk("config_out", config_out, m_act);
    chk("config_valid", CW'(config_valid), CW'(m_val));
    chk("config_error", CW'(config_error), CW'(m_err));
    chk("read_valid", CW'(bus.config_read_valid), CW'(m_rv));
    chk("read_data", CW'(bus.config_read_data), CW'(m_rd));
  endtask
  task automatic cycle(bit w, bit r, logic [31:0] a, logic [31:0] d);
    logic [31:0] off;
    bus.config_write = w; bus.config_read = r; bus.config_config_addr = a; bus.config_config_data = d;
    off = a - BASE;
    m_rv = r;
    if (r) m_rd = m_read(a);
    if (w && a >= BASE && off < NW) begin
      m_sh[off] = d;
      m_mask[off] = 1'b1;
    end else if (w && a >= BASE && off == NW && d[0]) begin
      if (&m_mask) begin
        m_act = image(); m_val = 1; m_err = 0; m_mask = '0;
      end else m_err = 1;
    end
    @(posedge clk); #1;
    bus.config_write = 0; bus.config_read = 0;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 0; #1;
    m_reset();
    check_all();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask
  initial begin
    int ord [NW];
    bus.config_write = 0; bus.config_read = 0; bus.config_config_addr = '0; bus.config_config_data = '0;
    m_reset();
    #2;
    do_reset();
    check_all();
    for (int i = 0; i < NW; i++) cycle(1, 0, BASE + i, 32'hA5A50000 + i);
    cycle(1, 0, BASE + NW, 32'h1);
    chk("t1_valid", CW'(config_valid), CW'(1));
    chk("t1_word0", CW'(config_out[31:0]), CW'(32'hA5A50000));
    chk("t1_last", CW'(config_out[549:544]), CW'(6'h11));
    cycle(1, 0, BASE + 3, 32'hDEADBEEF);
    chk("t3_hold", CW'(config_out[127:96]), CW'(32'hA5A50003));
    cycle(0, 1, BASE + 3, '0);
    chk("t3_read", CW'(bus.config_read_data), CW'(32'hDEADBEEF));
    cycle(0, 1, BASE + 17, '0);
    chk("t1_lastread", CW'(bus.config_read_data), CW'(32'h11));
    cycle(1, 0, BASE + 5, 32'h1);
    cycle(1, 1, BASE + 5, 32'h2);
    chk("t5_old", CW'(bus.config_read_data), CW'(32'h1));
    cycle(0, 1, BASE + 5, '0);
    chk("t5_new", CW'(bus.config_read_data), CW'(32'h2));
    cycle(1, 1, BASE + 19, 32'h1234);
    chk("t4_oor19", CW'({bus.config_read_valid, bus.config_read_data}), CW'({1'b1, 32'h0}));
    cycle(1, 1, 32'hFFFFFFFF, 32'h5678);
    chk("t4_oorff", CW'({bus.config_read_valid, bus.config_read_data}), CW'({1'b1, 32'h0}));
    cycle(1, 1, 32'd2, 32'h9ABC);
    chk("t4_below", CW'({bus.config_read_valid, bus.config_read_data}), CW'({1'b1, 32'h0}));
    for (int i = 0; i < NW; i++) cycle(0, 1, BASE + i, '0);
    do_reset();
    for (int i = 0; i < NW - 1; i++) cycle(1, 0, BASE + i, 32'h100 + i);
    cycle(1, 0, BASE + NW, 32'h1);
    chk("t2_err", CW'({config_error, config_valid}), CW'(2'b10));
    chk("t2_out", config_out, '0);
    cycle(1, 0, BASE + NW - 1, 32'h117);
    cycle(1, 0, BASE + NW, 32'h1);
    chk("t2_ok", CW'({config_error, config_valid}), CW'(2'b01));
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NW; i++) ord[i] = i;
      for (int i = NW - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(0, 5) == 0) cycle(1, 1, BASE + NW, $urandom);
        cycle(1, 1'($urandom_range(0, 1)), BASE + ord[i], $urandom);
      end
      cycle(1, 1, BASE + NW, 32'h1);
    end
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : BASE - 2 + $urandom_range(0, 23);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    for (int i = 0; i < NW; i++) cycle(1, 0, BASE + i, $urandom);
    cycle(1, 0, BASE + NW, 32'h1);
    for (int i = 0; i < 9; i++) cycle(1, 0, BASE + i, $urandom);
    #2 rst_n = 0; #1;
    m_reset();
    chk("t6_out", config_out, '0);
    chk("t6_flags", CW'({config_valid, config_error, bus.config_read_valid, bus.config_read_data}), '0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cycle(0, 1, BASE + NW, '0);
    chk("t6_status", CW'(bus.config_read_data), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lake_config_loader.md
# lake_config_loader

Address-mapped configuration responder for `lakespec`. Accepts the 32-bit serial config write/read transactions issued by the bench or the CGRA config bus (`config_config_addr`/`config_config_data`/`config_write`/`config_read`), assembles them into a double-buffered shadow image, and drives the flat `config_memory_size_550` vector on an explicit commit. This sits between the config bus and the wide config input of `lakespec`, replacing direct `$readmemh` loading of the flat vector.

## Interface
- `CONFIG_WIDTH`, 550, width of flat config vector
- `WORD_WIDTH`, 32, config data word width
- `ADDR_WIDTH`, 32, config address width
- `BASE_ADDR`, 0, word address of config word 0

Ports:
- `clk` in 1: sole clock
- `rst_n` in 1: asynchronous, active-low reset
- `config_config_addr` in ADDR_WIDTH: word address
- `config_config_data` in WORD_WIDTH: write data
- `config_write` in 1: write strobe, one transfer per cycle high
- `config_read` in 1: read strobe
- `config_read_data` out WORD_WIDTH: readback data
- `config_read_valid` out 1: readback qualifier
- `config_out` out CONFIG_WIDTH: active config, connects to `config_memory_size_550`
- `config_valid` out 1: active image committed
- `config_error` out 1: sticky, incomplete-image commit attempted

## Operation
- NUM_WORDS = ceil(CONFIG_WIDTH/WORD_WIDTH) = 18; word i maps to shadow bits [32i+31:32i]; last word holds 6 valid bits, upper 26 dropped on write, read as 0.
- Offset = addr − BASE_ADDR, unsigned ADDR_WIDTH; addr < BASE_ADDR is out of range.
- Offset 0..17: config word. Offset 18 (COMMIT): control register. Other offsets: writes ignored, reads return 0.
- Write to word i: shadow word i updated, `written_mask[i]` set. Rewrite of same word allowed, last write wins.
- Write to COMMIT with data[0]=1: if `written_mask` all ones → shadow copied to `config_out`, `config_valid`=1, `config_error` cleared, mask cleared. Else → no copy, `config_error`=1, mask and shadow kept. data[0]=0: no effect.
- FSM (state in package enum): LOAD (mask incomplete) → ARMED when final missing word written; ARMED → LOAD on successful commit. Failed commit only possible in LOAD, stays LOAD.
- Read of word i returns shadow (not active) word; read of COMMIT returns {29'b0, state==ARMED, config_error, config_valid}.
- Simultaneous `config_read` and `config_write`: both performed; read returns pre-write value.
- Reconfiguration while `config_valid`=1: `config_out` holds old image until next successful commit; no glitch on partial writes.

## Timing
- Reset (async assert, sync-to-clk deassert usage): `config_out`=0, shadow=0, mask=0, state LOAD, `config_valid`=0, `config_error`=0, `config_read_data`=0, `config_read_valid`=0.
- Write: sampled at rising edge where `config_write`=1; shadow visible to a read the following cycle.
- Commit: `config_out`/`config_valid` update at the same edge that samples the COMMIT write.
- Read latency 1: `config_read` sampled at edge N → `config_read_data` valid and `config_read_valid`=1 for one cycle after edge N; `config_read_data` holds last value when `config_read_valid`=0.
- Back-to-back reads/writes every cycle supported; no backpressure.
- Reset mid-load: all progress discarded, `config_out` drops to 0 immediately.

## Structure
- `lake_config_pkg`: NUM_WORDS, COMMIT_OFFSET, LAST_WORD_BITS, status bit positions, `cfg_state_t` {LOAD, ARMED}.
- One sub-module: `lake_config_word_mux` (combinational word select for readback, zero-fill of last word and out-of-range).
- Top holds shadow, mask, FSM, active register, read pipeline register.

## Test plan
- Write words 0..17 with 0xA5A50000+i, commit 1 → `config_valid`=1, `config_out[31:0]`=0xA5A50000, `config_out[549:544]`=0x11 (6 LSBs of 0xA5A50011).
- Write words 0..16 only, commit → `config_error`=1, `config_valid`=0, `config_out`=0; then write word 17, commit → error cleared, valid=1.
- Full load A, commit, rewrite word 3 with 0xDEADBEEF without commit → `config_out[127:96]` still image A; read addr 3 → 0xDEADBEEF one cycle later with `config_read_valid`.
- Read addr 19, addr 0xFFFFFFFF, and (BASE_ADDR=4) addr 2 → data 0, read_valid=1; writes there leave shadow unchanged.
- Same-cycle read+write addr 5 (old 0x1, new 0x2) → read returns 0x1; next read returns 0x2.
- Assert `rst_n`=0 after 9 words loaded of a second image with first committed → all outputs 0 asynchronously; status read of COMMIT returns 0.
